node_port: RTL and testbench

NODE_PORT -- requirements
Module: node_port

---
 rtl/node_port_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 61 ++++++
 rtl/node_port.sv | 128 ++++++++++++
 tb/tb_node_port.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/node_port_pkg.sv
// Shared widths, packet layout and outbound FSM encoding for the node port.
package node_port_pkg;

  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned PAYLOAD_W = 24;
  localparam int unsigned PKT_W     = 29;

  typedef struct packed {
    logic [ADDR_W-1:0]    dest;
    logic                 ptype;
    logic [PAYLOAD_W-1:0] payload;
  } pkt_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_HOLDOFF = 2'd2
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with registered full/empty flags.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head_c,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             do_push_c;
  logic             do_pop_c;

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  always_comb begin
    do_pop_c  = pop & ~empty;
    do_push_c = push & (~full | do_pop_c);
    count_nxt = count;
    if (do_push_c && !do_pop_c) begin
      count_nxt = count + CNT_W'(1);
    end else if (do_pop_c && !do_push_c) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      full  <= (count_nxt == CNT_W'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_c) mem[wr_ptr] <= din;
  end

  assign head_c = mem[rd_ptr];

endmodule

// File: rtl/node_port.sv
// Node-side port: queues outbound requests to the router core with ack/retry,
// and buffers inbound packets for the node with overflow accounting.
module node_port
  import node_port_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic                 Clk_R,
  input  logic                 Rst,
  input  logic                 Req_Valid,
  output logic                 Req_Ready,
  input  logic [ADDR_W-1:0]    Req_Dest,
  input  logic                 Req_Type,
  input  logic [PAYLOAD_W-1:0] Req_Payload,
  output logic [PKT_W-1:0]     Packet_From_Node,
  output logic                 Packet_From_Node_Valid,
  input  logic                 Core_Load_Ack,
  input  logic [PAYLOAD_W-1:0] Packet_To_Node,
  input  logic                 Packet_To_Node_Valid,
  output logic                 Rsp_Valid,
  input  logic                 Rsp_Ready,
  output logic [PAYLOAD_W-1:0] Rsp_Payload,
  output logic [7:0]           Rx_Overflow_Cnt,
  output logic                 Tx_Timeout
);

  localparam int unsigned TIMER_W = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);

  pkt_t                 tx_din;
  logic [PKT_W-1:0]     tx_head_c;
  logic                 tx_full;
  logic                 tx_empty;
  logic                 tx_push_c;
  logic                 tx_pop_c;
  logic [PAYLOAD_W-1:0] rx_head_c;
  logic                 rx_full;
  logic                 rx_empty;
  logic                 rx_push_c;
  logic                 rx_pop_c;
  logic                 rx_drop_c;
  tx_state_t            state;
  tx_state_t            state_nxt;
  logic [TIMER_W-1:0]   timer;
  logic [TIMER_W-1:0]   timer_nxt;
  logic                 timeout_set_c;

  assign tx_din    = '{dest: Req_Dest, ptype: Req_Type, payload: Req_Payload};
  assign Req_Ready = ~tx_full & ~Rst;
  assign tx_push_c = Req_Valid & Req_Ready;

  sync_fifo #(.WIDTH(PKT_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk    (Clk_R),
    .rst    (Rst),
    .push   (tx_push_c),
    .pop    (tx_pop_c),
    .din    (tx_din),
    .head_c (tx_head_c),
    .full   (tx_full),
    .empty  (tx_empty)
  );

  // Outbound handshake: present head, wait for ack or timeout, then one idle gap.
  always_comb begin
    state_nxt     = state;
    timer_nxt     = timer;
    tx_pop_c      = 1'b0;
    timeout_set_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!tx_empty) state_nxt = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (Core_Load_Ack) begin
          tx_pop_c  = 1'b1;
          timer_nxt = '0;
          state_nxt = ST_HOLDOFF;
        end else if (timer == TIMER_W'(ACK_TIMEOUT)) begin
          timeout_set_c = 1'b1;
          timer_nxt     = '0;
          state_nxt     = ST_HOLDOFF;
        end else begin
          timer_nxt = timer + TIMER_W'(1);
        end
      end
      ST_HOLDOFF: state_nxt = ST_IDLE;
      default: begin
        state_nxt = ST_IDLE;
        timer_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge Clk_R) begin
    if (Rst) begin
      state           <= ST_IDLE;
      timer           <= '0;
      Tx_Timeout      <= 1'b0;
      Rx_Overflow_Cnt <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      if (timeout_set_c) Tx_Timeout <= 1'b1;
      if (rx_drop_c && (Rx_Overflow_Cnt != 8'hFF)) Rx_Overflow_Cnt <= Rx_Overflow_Cnt + 8'd1;
    end
  end

  assign Packet_From_Node_Valid = (state == ST_PRESENT);
  assign Packet_From_Node       = Packet_From_Node_Valid ? tx_head_c : '0;

  assign Rsp_Valid   = ~rx_empty;
  assign Rsp_Payload = rx_empty ? '0 : rx_head_c;
  assign rx_pop_c    = Rsp_Valid & Rsp_Ready;
  assign rx_push_c   = Packet_To_Node_Valid & (~rx_full | rx_pop_c);
  assign rx_drop_c   = Packet_To_Node_Valid & rx_full & ~rx_pop_c;

  sync_fifo #(.WIDTH(PAYLOAD_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk    (Clk_R),
    .rst    (Rst),
    .push   (rx_push_c),
    .pop    (rx_pop_c),
    .din    (Packet_To_Node),
    .head_c (rx_head_c),
    .full   (rx_full),
    .empty  (rx_empty)
  );

endmodule

// File: tb/tb_node_port.sv
// Directed self-checking bench for node_port: outbound handshake, timeout/retry,
// inbound overflow and mid-operation reset.
module tb_node_port;

  logic        Clk_R = 1'b0;
  logic        Rst;
  logic        Req_Valid;
  logic        Req_Ready;
  logic [3:0]  Req_Dest;
  logic        Req_Type;
  logic [23:0] Req_Payload;
  logic [28:0] Packet_From_Node;
  logic        Packet_From_Node_Valid;
  logic        Core_Load_Ack;
  logic [23:0] Packet_To_Node;
  logic        Packet_To_Node_Valid;
  logic        Rsp_Valid;
  logic        Rsp_Ready;
  logic [23:0] Rsp_Payload;
  logic [7:0]  Rx_Overflow_Cnt;
  logic        Tx_Timeout;

  int n_checks = 0;
  int n_pass   = 0;

  node_port #(.FIFO_DEPTH(4), .ACK_TIMEOUT(255)) dut (
    .Clk_R                  (Clk_R),
    .Rst                    (Rst),
    .Req_Valid              (Req_Valid),
    .Req_Ready              (Req_Ready),
    .Req_Dest               (Req_Dest),
    .Req_Type               (Req_Type),
    .Req_Payload            (Req_Payload),
    .Packet_From_Node       (Packet_From_Node),
    .Packet_From_Node_Valid (Packet_From_Node_Valid),
    .Core_Load_Ack          (Core_Load_Ack),
    .Packet_To_Node         (Packet_To_Node),
    .Packet_To_Node_Valid   (Packet_To_Node_Valid),
    .Rsp_Valid              (Rsp_Valid),
    .Rsp_Ready              (Rsp_Ready),
    .Rsp_Payload            (Rsp_Payload),
    .Rx_Overflow_Cnt        (Rx_Overflow_Cnt),
    .Tx_Timeout             (Tx_Timeout)
  );

  always #5 Clk_R = ~Clk_R;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge Clk_R);
    #1;
  endtask

  task automatic push_req(input logic [3:0] d, input logic t, input logic [23:0] p);
    Req_Valid   = 1'b1;
    Req_Dest    = d;
    Req_Type    = t;
    Req_Payload = p;
    step();
    Req_Valid   = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int waited = 0;
    while (!Packet_From_Node_Valid && waited < budget) begin
      step();
      waited++;
    end
    check(tag, 32'(Packet_From_Node_Valid), 32'd1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_valid"},   32'(Packet_From_Node_Valid), 32'd0);
    check({pfx, "_pkt"},     32'(Packet_From_Node),       32'd0);
    check({pfx, "_ready"},   32'(Req_Ready),              32'd0);
    check({pfx, "_rspv"},    32'(Rsp_Valid),              32'd0);
    check({pfx, "_rspp"},    32'(Rsp_Payload),            32'd0);
    check({pfx, "_ovf"},     32'(Rx_Overflow_Cnt),        32'd0);
    check({pfx, "_timeout"}, 32'(Tx_Timeout),             32'd0);
  endtask

  logic [28:0] exp_pkt;
  logic [23:0] rx_exp [4];
  int          n;

  initial begin
    Rst = 1'b1;
    Req_Valid = 1'b0; Req_Dest = '0; Req_Type = 1'b0; Req_Payload = '0;
    Core_Load_Ack = 1'b0; Packet_To_Node = '0; Packet_To_Node_Valid = 1'b0; Rsp_Ready = 1'b0;
    repeat (2) step();
    check_reset_outputs("rst");
    Rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(Req_Ready), 32'd1);

    // Single request, acked 3 cycles after it is presented
    push_req(4'd1, 1'b0, 24'd42);
    check("t1_n1_valid", 32'(Packet_From_Node_Valid), 32'd0);
    step();
    exp_pkt = {4'd1, 1'b0, 24'd42};
    check("t1_n2_valid", 32'(Packet_From_Node_Valid), 32'd1);
    check("t1_pkt", 32'(Packet_From_Node), 32'(exp_pkt));
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("t1_hold%0d", i), 32'(Packet_From_Node), 32'(exp_pkt));
    end
    Core_Load_Ack = 1'b1;
    step();
    Core_Load_Ack = 1'b0;
    check("t1_holdoff", 32'(Packet_From_Node_Valid), 32'd0);
    step();
    check("t1_idle", 32'(Packet_From_Node_Valid), 32'd0);
    step();
    check("t1_empty", 32'(Packet_From_Node_Valid), 32'd0);
    check("t1_ready", 32'(Req_Ready), 32'd1);

    // Five back-to-back requests: only four fit
    for (int i = 0; i < 5; i++) begin
      Req_Valid   = 1'b1;
      Req_Dest    = 4'(i);
      Req_Type    = i[0];
      Req_Payload = 24'(100 + i);
      check($sformatf("t2_ready%0d", i), 32'(Req_Ready), (i < 4) ? 32'd1 : 32'd0);
      step();
    end
    Req_Valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_valid($sformatf("t2_wait%0d", k), 8);
      check($sformatf("t2_payload%0d", k), 32'(Packet_From_Node[23:0]), 32'(100 + k));
      check($sformatf("t2_dest%0d", k), 32'(Packet_From_Node[28:25]), 32'(k));
      Core_Load_Ack = 1'b1;
      step();
      step();            // ack held through HOLDOFF must be ignored
      Core_Load_Ack = 1'b0;
    end
    step();
    check("t2_drained", 32'(Packet_From_Node_Valid), 32'd0);
    check("t2_ready_after", 32'(Req_Ready), 32'd1);

    // Ack landing on the timeout cycle wins
    push_req(4'd2, 1'b0, 24'h000055);
    wait_valid("t3_wait", 8);
    repeat (255) step();
    check("t3_still_valid", 32'(Packet_From_Node_Valid), 32'd1);
    Core_Load_Ack = 1'b1;
    step();
    Core_Load_Ack = 1'b0;
    check("t3_valid_low", 32'(Packet_From_Node_Valid), 32'd0);
    check("t3_no_timeout", 32'(Tx_Timeout), 32'd0);
    repeat (3) step();
    check("t3_popped", 32'(Packet_From_Node_Valid), 32'd0);

    // No ack: timeout after 256 presenting cycles, then retry of the same packet
    push_req(4'd3, 1'b1, 24'h0ABCDE);
    exp_pkt = {4'd3, 1'b1, 24'h0ABCDE};
    wait_valid("t4_wait", 8);
    n = 0;
    while (Packet_From_Node_Valid && n < 300) begin
      step();
      n++;
    end
    check("t4_present_len", 32'(n), 32'd256);
    check("t4_timeout", 32'(Tx_Timeout), 32'd1);
    step();
    check("t4_gap", 32'(Packet_From_Node_Valid), 32'd0);
    step();
    check("t4_retry_valid", 32'(Packet_From_Node_Valid), 32'd1);
    check("t4_retry_pkt", 32'(Packet_From_Node), 32'(exp_pkt));
    Core_Load_Ack = 1'b1;
    step();
    Core_Load_Ack = 1'b0;
    check("t4_sticky", 32'(Tx_Timeout), 32'd1);
    repeat (3) step();
    check("t4_popped", 32'(Packet_From_Node_Valid), 32'd0);

    // Inbound overflow: six pulses into a four-deep FIFO
    for (int v = 1; v <= 6; v++) begin
      Packet_To_Node_Valid = 1'b1;
      Packet_To_Node       = 24'(v);
      step();
    end
    Packet_To_Node_Valid = 1'b0;
    check("t5_ovf", 32'(Rx_Overflow_Cnt), 32'd2);
    check("t5_rspv", 32'(Rsp_Valid), 32'd1);
    check("t5_head", 32'(Rsp_Payload), 32'd1);
    // Push coinciding with a pop on a full FIFO is not a drop
    Packet_To_Node_Valid = 1'b1;
    Packet_To_Node       = 24'd7;
    Rsp_Ready            = 1'b1;
    step();
    Packet_To_Node_Valid = 1'b0;
    Rsp_Ready            = 1'b0;
    check("t5_nodrop_ovf", 32'(Rx_Overflow_Cnt), 32'd2);
    check("t5_nodrop_head", 32'(Rsp_Payload), 32'd2);
    Packet_To_Node_Valid = 1'b1;
    Packet_To_Node       = 24'd8;
    step();
    Packet_To_Node_Valid = 1'b0;
    check("t5_still_full", 32'(Rx_Overflow_Cnt), 32'd3);
    rx_exp[0] = 24'd2; rx_exp[1] = 24'd3; rx_exp[2] = 24'd4; rx_exp[3] = 24'd7;
    Rsp_Ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t5_rspv%0d", k), 32'(Rsp_Valid), 32'd1);
      check($sformatf("t5_rsp%0d", k), 32'(Rsp_Payload), 32'(rx_exp[k]));
      step();
    end
    Rsp_Ready = 1'b0;
    check("t5_empty_v", 32'(Rsp_Valid), 32'd0);
    check("t5_empty_p", 32'(Rsp_Payload), 32'd0);
    // Counter saturates at 255
    Packet_To_Node_Valid = 1'b1;
    for (int j = 0; j < 264; j++) begin
      Packet_To_Node = 24'(j + 16);
      step();
    end
    Packet_To_Node_Valid = 1'b0;
    check("t5_saturate", 32'(Rx_Overflow_Cnt), 32'd255);
    check("t5_sat_head", 32'(Rsp_Payload), 32'd16);

    // Reset while presenting with three queued requests and a full RX FIFO
    push_req(4'd4, 1'b0, 24'h000011);
    push_req(4'd5, 1'b0, 24'h000022);
    push_req(4'd6, 1'b0, 24'h000033);
    wait_valid("t6_wait", 8);
    Rst = 1'b1;
    Core_Load_Ack = 1'b1;
    step();
    check_reset_outputs("t6");
    step();
    Rst = 1'b0;
    Core_Load_Ack = 1'b0;
    #1;
    check("t6_ready_after", 32'(Req_Ready), 32'd1);
    repeat (3) step();
    check("t6_tx_discarded", 32'(Packet_From_Node_Valid), 32'd0);
    check("t6_rx_discarded", 32'(Rsp_Valid), 32'd0);
    push_req(4'd9, 1'b1, 24'h000099);
    exp_pkt = {4'd9, 1'b1, 24'h000099};
    wait_valid("t6_new_wait", 8);
    check("t6_new_pkt", 32'(Packet_From_Node), 32'(exp_pkt));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
